// File: rtl/decode_queue.sv
// decode_queue: RV32I (+ optional Zbb, M) decoder feeding a DEPTH-entry FIFO.
//
// Sits between fetch and operand read. Each accepted instruction is decoded
// combinationally and stored, together with its pc and raw word, in the tail
// entry. The head entry is presented on out_* one cycle after it was pushed.
// Illegal encodings are still queued, carrying out_illegal=1 and a neutral
// control bundle.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               drop every queued entry; a push in the same cycle is ignored
//   in_valid/in_ready   fetch-side handshake; in_ready depends only on occupancy
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready consumer-side handshake for the head entry
//   out_*               decoded control bundle; all zero while out_valid=0
//   occupancy           number of entries held
//
// ALU_* encoding (out_alu_sel):
//   0 NOP   1 ADD   2 SUB   3 SLL   4 SLT   5 SLTU  6 XOR   7 SRL
//   8 SRA   9 OR   10 AND  11 ANDN 12 ORN  13 XNOR 14 MIN  15 MINU
//  16 MAX  17 MAXU 18 ROL  19 ROR  20 CLZ  21 CTZ  22 CPOP 23 SEXTB
//  24 SEXTH 25 ZEXTH 26 ORCB 27 REV8
// IMM_TYPE_* encoding (out_imm_sel): 0 I, 1 S, 2 B, 3 U, 4 J

module decode_queue #(
  parameter int DEPTH      = 2,
  parameter int ENABLE_ZBB = 1,
  parameter int ENABLE_M   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_alu_sel,
  output logic                       out_alu_src,
  output logic                       out_alu_pc_src,
  output logic                       out_reg_write,
  output logic                       out_mem_read,
  output logic                       out_mem_write,
  output logic                       out_mem_to_reg,
  output logic                       out_branch,
  output logic                       out_jump,
  output logic [2:0]                 out_imm_sel,
  output logic                       out_md_en,
  output logic [2:0]                 out_md_op,
  output logic [2:0]                 out_funct3,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [4:0] ALU_NOP = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_SLL   = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4,  ALU_SLTU = 5'd5,  ALU_XOR  = 5'd6,  ALU_SRL   = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8,  ALU_OR   = 5'd9,  ALU_AND  = 5'd10, ALU_ANDN  = 5'd11;
  localparam logic [4:0] ALU_ORN = 5'd12, ALU_XNOR = 5'd13, ALU_MIN  = 5'd14, ALU_MINU  = 5'd15;
  localparam logic [4:0] ALU_MAX = 5'd16, ALU_MAXU = 5'd17, ALU_ROL  = 5'd18, ALU_ROR   = 5'd19;
  localparam logic [4:0] ALU_CLZ = 5'd20, ALU_CTZ  = 5'd21, ALU_CPOP = 5'd22, ALU_SEXTB = 5'd23;
  localparam logic [4:0] ALU_SEXTH = 5'd24, ALU_ZEXTH = 5'd25, ALU_ORCB = 5'd26, ALU_REV8 = 5'd27;

  localparam logic [2:0] IMM_TYPE_I = 3'd0, IMM_TYPE_S = 3'd1, IMM_TYPE_B = 3'd2;
  localparam logic [2:0] IMM_TYPE_U = 3'd3, IMM_TYPE_J = 3'd4;

  localparam logic [6:0] OPC_OP    = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111, OPC_LUI   = 7'b0110111, OPC_AUIPC = 7'b0010111;

  // Full 12-bit immediates of the two OP-IMM/funct3=101 Zbb unary ops.
  localparam logic [11:0] IMM12_ORCB = 12'h287;
  localparam logic [11:0] IMM12_REV8 = 12'h698;

  typedef struct packed {
    logic [4:0]  alu_sel;
    logic        alu_src;
    logic        alu_pc_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic [2:0]  imm_sel;
    logic        md_en;
    logic [2:0]  md_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  entry_t     dec;
  logic       is_zbb;
  logic       ill;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs2f;

  assign opc  = in_instr[6:0];
  assign f3   = in_instr[14:12];
  assign f7   = in_instr[31:25];
  assign rs2f = in_instr[24:20];

  always_comb begin
    dec        = '0;
    is_zbb     = 1'b0;
    ill        = 1'b0;
    dec.funct3 = f3;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = rs2f;
    dec.pc     = in_pc;
    dec.instr  = in_instr;
    dec.imm_sel = IMM_TYPE_I;
    case (opc)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: dec.alu_sel = ALU_ADD;
              3'b001: dec.alu_sel = ALU_SLL;
              3'b010: dec.alu_sel = ALU_SLT;
              3'b011: dec.alu_sel = ALU_SLTU;
              3'b100: dec.alu_sel = ALU_XOR;
              3'b101: dec.alu_sel = ALU_SRL;
              3'b110: dec.alu_sel = ALU_OR;
              3'b111: dec.alu_sel = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  dec.alu_sel = ALU_SUB;
              3'b101:  dec.alu_sel = ALU_SRA;
              3'b100:  begin dec.alu_sel = ALU_XNOR; is_zbb = 1'b1; end
              3'b110:  begin dec.alu_sel = ALU_ORN;  is_zbb = 1'b1; end
              3'b111:  begin dec.alu_sel = ALU_ANDN; is_zbb = 1'b1; end
              default: ill = 1'b1;
            endcase
          end
          7'b0000001: begin
            if (ENABLE_M != 0) begin
              dec.md_en   = 1'b1;
              dec.md_op   = f3;
              dec.alu_sel = ALU_NOP;
            end else begin
              ill = 1'b1;
            end
          end
          7'b0000101: begin
            is_zbb = 1'b1;
            case (f3)
              3'b100:  dec.alu_sel = ALU_MIN;
              3'b101:  dec.alu_sel = ALU_MINU;
              3'b110:  dec.alu_sel = ALU_MAX;
              3'b111:  dec.alu_sel = ALU_MAXU;
              default: ill = 1'b1;
            endcase
          end
          7'b0110000: begin
            is_zbb = 1'b1;
            case (f3)
              3'b001:  dec.alu_sel = ALU_ROL;
              3'b101:  dec.alu_sel = ALU_ROR;
              default: ill = 1'b1;
            endcase
          end
          7'b0000100: begin
            is_zbb = 1'b1;
            if (f3 == 3'b100 && rs2f == 5'd0) dec.alu_sel = ALU_ZEXTH;
            else                             ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (f3)
          3'b000: dec.alu_sel = ALU_ADD;
          3'b010: dec.alu_sel = ALU_SLT;
          3'b011: dec.alu_sel = ALU_SLTU;
          3'b100: dec.alu_sel = ALU_XOR;
          3'b110: dec.alu_sel = ALU_OR;
          3'b111: dec.alu_sel = ALU_AND;
          3'b001: begin
            // RV32 shamt is 5 bits, so instr[25]=1 lands in the illegal arm.
            if (f7 == 7'b0000000) begin
              dec.alu_sel = ALU_SLL;
            end else if (f7 == 7'b0110000) begin
              is_zbb = 1'b1;
              case (rs2f)
                5'd0:    dec.alu_sel = ALU_CLZ;
                5'd1:    dec.alu_sel = ALU_CTZ;
                5'd2:    dec.alu_sel = ALU_CPOP;
                5'd4:    dec.alu_sel = ALU_SEXTB;
                5'd5:    dec.alu_sel = ALU_SEXTH;
                default: ill = 1'b1;
              endcase
            end else begin
              ill = 1'b1;
            end
          end
          3'b101: begin
            if (f7 == 7'b0000000)                  dec.alu_sel = ALU_SRL;
            else if (f7 == 7'b0100000)             dec.alu_sel = ALU_SRA;
            else if (f7 == 7'b0110000)             begin dec.alu_sel = ALU_ROR;  is_zbb = 1'b1; end
            else if (in_instr[31:20] == IMM12_ORCB) begin dec.alu_sel = ALU_ORCB; is_zbb = 1'b1; end
            else if (in_instr[31:20] == IMM12_REV8) begin dec.alu_sel = ALU_REV8; is_zbb = 1'b1; end
            else                                   ill = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        dec.alu_sel    = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_sel   = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm_sel   = IMM_TYPE_S;
        if (f3 >= 3'b011) ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_sel = ALU_NOP;
        dec.imm_sel = IMM_TYPE_B;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_sel   = ALU_ADD;
        dec.imm_sel   = IMM_TYPE_J;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_sel   = ALU_ADD;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_sel    = ALU_ADD;
        dec.imm_sel    = IMM_TYPE_U;
        dec.alu_pc_src = (opc == OPC_AUIPC);
      end
      default: ill = 1'b1;
    endcase

    if (is_zbb && ENABLE_ZBB == 0) ill = 1'b1;

    // Illegal entries still flow down the pipe but must not cause side effects.
    if (ill) begin
      dec.alu_sel    = ALU_NOP;
      dec.alu_src    = 1'b0;
      dec.alu_pc_src = 1'b0;
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.imm_sel    = IMM_TYPE_I;
      dec.md_en      = 1'b0;
      dec.md_op      = 3'b000;
      dec.illegal    = 1'b1;
    end
  end

  // ------------------------------------------------------------------ FIFO
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               push, pop;
  entry_t             head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q != OCC_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: its contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec;
  end

  assign head = out_valid ? mem_q[head_q] : '0;

  assign out_alu_sel    = head.alu_sel;
  assign out_alu_src    = head.alu_src;
  assign out_alu_pc_src = head.alu_pc_src;
  assign out_reg_write  = head.reg_write;
  assign out_mem_read   = head.mem_read;
  assign out_mem_write  = head.mem_write;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_branch     = head.branch;
  assign out_jump       = head.jump;
  assign out_imm_sel    = head.imm_sel;
  assign out_md_en      = head.md_en;
  assign out_md_op      = head.md_op;
  assign out_funct3     = head.funct3;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_illegal    = head.illegal;
  assign occupancy      = count_q;

endmodule
